// File: rtl/hazard_unit_if.sv
// hazard_unit_if: decode/execute hazard inputs and stall/flush controls for hazard_unit
interface hazard_unit_if #(parameter int CNT_W = 16);
  logic valid_dec, use_rn_dec, use_rm_dec, use_rs_dec;
  logic [3:0] rn_dec, rm_dec, rs_dec, rd_ex;
  logic valid_ex, load_ex, branch_taken_ex;
  logic sel_stall, branch_flush, en_pc, busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output valid_dec, rn_dec, rm_dec, rs_dec, use_rn_dec, use_rm_dec, use_rs_dec,
           valid_ex, load_ex, rd_ex, branch_taken_ex,
    input  sel_stall, branch_flush, en_pc, stall_cnt, flush_cnt, busy
  );
  modport slave (
    input  valid_dec, rn_dec, rm_dec, rs_dec, use_rn_dec, use_rm_dec, use_rs_dec,
           valid_ex, load_ex, rd_ex, branch_taken_ex,
    output sel_stall, branch_flush, en_pc, stall_cnt, flush_cnt, busy
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: load-use bubble insertion, taken-branch flush and saturating event counters
module hazard_unit #(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave h
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic hz, stall, flush;
  assign hz = h.valid_dec & h.valid_ex & h.load_ex &
              ((h.use_rn_dec & (h.rn_dec == h.rd_ex)) |
               (h.use_rm_dec & (h.rm_dec == h.rd_ex)) |
               (h.use_rs_dec & (h.rs_dec == h.rd_ex)));
  // A taken branch wins in every state: the decode instruction is wrong-path.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    flush    = 1'b0;
    if (h.branch_taken_ex) begin
      flush    = 1'b1;
      state_nx = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_nx   = 3'(FLUSH_CYCLES - 1);
    end else begin
      case (state)
        RUN: if (hz) begin
          stall    = 1'b1;
          state_nx = (LOAD_LAT > 1) ? STALL : RUN;
          cnt_nx   = 3'(LOAD_LAT - 1);
        end
        STALL: begin
          stall    = 1'b1;
          cnt_nx   = cnt - 3'd1;
          state_nx = (cnt == 3'd1) ? RUN : STALL;
        end
        FLUSH: begin
          flush    = 1'b1;
          cnt_nx   = cnt - 3'd1;
          state_nx = (cnt == 3'd1) ? RUN : FLUSH;
        end
        default: state_nx = RUN;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= 3'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      stall_q <= stall_q + CNT_W'(stall && !(&stall_q));
      flush_q <= flush_q + CNT_W'(flush && !(&flush_q));
    end
  end
  assign h.sel_stall    = stall;
  assign h.branch_flush = flush;
  assign h.en_pc        = ~stall;
  assign h.busy         = (state != RUN);
  assign h.stall_cnt    = stall_q;
  assign h.flush_cnt    = flush_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard_unit across three parameter sets
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic valid_dec, use_rn, use_rm, use_rs, valid_ex, load_ex, br;
  logic [3:0] rn, rm, rs, rd;
  int checks = 0;
  int errors = 0;
  hazard_unit_if #(.CNT_W(16)) ia ();
  hazard_unit_if #(.CNT_W(16)) ib ();
  hazard_unit_if #(.CNT_W(4))  ic ();
  hazard_unit #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .h(ia.slave));
  hazard_unit #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(16)) u_b (.clk(clk), .rst_n(rst_n), .h(ib.slave));
  hazard_unit #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(4))  u_c (.clk(clk), .rst_n(rst_n), .h(ic.slave));
  logic [22:0] in_v;
  assign in_v = {valid_dec, rn, rm, rs, use_rn, use_rm, use_rs, valid_ex, load_ex, rd, br};
  assign {ia.valid_dec, ia.rn_dec, ia.rm_dec, ia.rs_dec, ia.use_rn_dec, ia.use_rm_dec, ia.use_rs_dec,
          ia.valid_ex, ia.load_ex, ia.rd_ex, ia.branch_taken_ex} = in_v;
  assign {ib.valid_dec, ib.rn_dec, ib.rm_dec, ib.rs_dec, ib.use_rn_dec, ib.use_rm_dec, ib.use_rs_dec,
          ib.valid_ex, ib.load_ex, ib.rd_ex, ib.branch_taken_ex} = in_v;
  assign {ic.valid_dec, ic.rn_dec, ic.rm_dec, ic.rs_dec, ic.use_rn_dec, ic.use_rm_dec, ic.use_rs_dec,
          ic.valid_ex, ic.load_ex, ic.rd_ex, ic.branch_taken_ex} = in_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {valid_dec, use_rn, use_rm, use_rs, valid_ex, load_ex, br} = '0;
    {rn, rm, rs, rd} = '0;
  endtask

  task automatic load_use_rm3();
    idle();
    valid_dec = 1'b1; use_rm = 1'b1; rm = 4'd3;
    valid_ex = 1'b1; load_ex = 1'b1; rd = 4'd3;
  endtask

  task automatic reset_pulse();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_sel_stall", ia.sel_stall, 0);
    check("rst_flush", ia.branch_flush, 0);
    check("rst_en_pc", ia.en_pc, 1);
    check("rst_busy", ia.busy, 0);
    check("rst_stall_cnt", ia.stall_cnt, 0);
    check("rst_flush_cnt", ia.flush_cnt, 0);
    // load-use on Rm, one bubble, then execute holds a NOP
    load_use_rm3();
    #1;
    check("lu_rm_sel", ia.sel_stall, 1);
    check("lu_rm_en_pc", ia.en_pc, 0);
    check("lu_rm_busy", ia.busy, 0);
    tick();
    valid_ex = 1'b0;
    #1;
    check("lu_rm_after_sel", ia.sel_stall, 0);
    check("lu_rm_after_en_pc", ia.en_pc, 1);
    check("lu_rm_stall_cnt", ia.stall_cnt, 1);
    load_use_rm3(); use_rm = 1'b0;
    #1 check("no_use_rm", ia.sel_stall, 0);
    use_rm = 1'b1; valid_ex = 1'b0;
    #1 check("no_valid_ex", ia.sel_stall, 0);
    valid_ex = 1'b1; load_ex = 1'b0;
    #1 check("non_load", ia.sel_stall, 0);
    load_ex = 1'b1; valid_dec = 1'b0;
    #1 check("no_valid_dec", ia.sel_stall, 0);
    use_rn = 1'b1; rn = 4'd3; use_rm = 1'b0; use_rs = 1'b1; rs = 4'd3; valid_dec = 1'b1; rd = 4'd4;
    #1 check("reg_mismatch", ia.sel_stall, 0);
    idle();
    tick();
    check("no_stall_cnt", ia.stall_cnt, 1);
    valid_dec = 1'b1; use_rn = 1'b1; rn = 4'd2; use_rs = 1'b1; rs = 4'd7;
    valid_ex = 1'b1; load_ex = 1'b1; rd = 4'd7;
    #1 check("lu_rs_sel", ia.sel_stall, 1);
    tick();
    idle();
    #1 check("lu_rs_stall_cnt", ia.stall_cnt, 2);
    valid_dec = 1'b1; use_rn = 1'b1; rn = 4'd9; valid_ex = 1'b1; load_ex = 1'b1; rd = 4'd9;
    #1 check("lu_rn_sel", ia.sel_stall, 1);
    reset_pulse();
    check("rst2_stall_cnt", ia.stall_cnt, 0);
    check("rst2_b_busy", ib.busy, 0);
    // taken branch, two flush cycles
    br = 1'b1;
    #1;
    check("br_t_flush", ia.branch_flush, 1);
    check("br_t_en_pc", ia.en_pc, 1);
    check("br_t_sel", ia.sel_stall, 0);
    tick();
    br = 1'b0;
    #1;
    check("br_t1_flush", ia.branch_flush, 1);
    check("br_t1_busy", ia.busy, 1);
    check("br_t1_en_pc", ia.en_pc, 1);
    tick();
    check("br_t2_flush", ia.branch_flush, 0);
    check("br_t2_busy", ia.busy, 0);
    check("br_flush_cnt", ia.flush_cnt, 2);
    // branch and hazard together: branch wins, hazard ignored during FLUSH
    load_use_rm3(); br = 1'b1;
    #1;
    check("brhz_flush", ia.branch_flush, 1);
    check("brhz_sel", ia.sel_stall, 0);
    tick();
    br = 1'b0;
    #1;
    check("flush_hz_flush", ia.branch_flush, 1);
    check("flush_hz_sel", ia.sel_stall, 0);
    idle();
    tick();
    check("brhz_flush_end", ia.branch_flush, 0);
    check("brhz_stall_cnt", ia.stall_cnt, 0);
    check("brhz_flush_cnt", ia.flush_cnt, 4);
    // LOAD_LAT=3: three bubbles
    reset_pulse();
    load_use_rm3();
    #1 check("ll3_t_sel", ib.sel_stall, 1);
    tick();
    valid_ex = 1'b0;
    #1;
    check("ll3_t1_sel", ib.sel_stall, 1);
    check("ll3_t1_busy", ib.busy, 1);
    tick();
    check("ll3_t2_sel", ib.sel_stall, 1);
    check("ll3_t2_en_pc", ib.en_pc, 0);
    tick();
    check("ll3_t3_sel", ib.sel_stall, 0);
    check("ll3_t3_busy", ib.busy, 0);
    check("ll3_stall_cnt", ib.stall_cnt, 3);
    // LOAD_LAT=3 stall aborted by a branch one cycle later
    load_use_rm3();
    tick();
    valid_ex = 1'b0; br = 1'b1;
    #1;
    check("ll3br_t1_sel", ib.sel_stall, 0);
    check("ll3br_t1_flush", ib.branch_flush, 1);
    tick();
    br = 1'b0;
    #1;
    check("ll3br_t2_flush", ib.branch_flush, 1);
    check("ll3br_t2_sel", ib.sel_stall, 0);
    tick();
    check("ll3br_t3_flush", ib.branch_flush, 0);
    check("ll3br_t3_busy", ib.busy, 0);
    check("ll3br_stall_cnt", ib.stall_cnt, 4);
    check("ll3br_flush_cnt", ib.flush_cnt, 2);
    // reset in the middle of a flush
    idle(); br = 1'b1;
    tick();
    br = 1'b0;
    #1 check("rstfl_busy_before", ia.busy, 1);
    reset_pulse();
    check("rstfl_busy", ia.busy, 0);
    check("rstfl_flush", ia.branch_flush, 0);
    check("rstfl_stall_cnt", ia.stall_cnt, 0);
    check("rstfl_flush_cnt", ia.flush_cnt, 0);
    // 20 continuous stall cycles: 4-bit counter saturates
    load_use_rm3();
    repeat (20) tick();
    idle();
    #1;
    check("sat_c_stall_cnt", ic.stall_cnt, 15);
    check("sat_a_stall_cnt", ia.stall_cnt, 20);
    check("sat_c_flush_cnt", ic.flush_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller. It produces the stall and branch-flush controls consumed by every stage's pipeline_unit (sel_stall, branch_in).
- Execute and memory stage controllers resolve data dependencies by forwarding. This block handles the cases forwarding cannot cover: it inserts load-use bubbles and squashes wrong-path instructions after a taken branch.
- It also keeps saturating stall/flush event counters for performance debug.

Parameters:
- LOAD_LAT, 1: bubble cycles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 2: cycles branch_flush is held after a taken branch (1..7).
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- valid_dec  in  1  decode-stage instruction is real (not NOP/squashed)
- rn_dec  in  4  decode-stage Rn
- rm_dec  in  4  decode-stage Rm
- rs_dec  in  4  decode-stage Rs
- use_rn_dec  in  1  decode instruction reads Rn
- use_rm_dec  in  1  decode instruction reads Rm
- use_rs_dec  in  1  decode instruction reads Rs
- valid_ex  in  1  execute-stage instruction is real
- load_ex  in  1  execute-stage instruction is LDR (any addressing form)
- rd_ex  in  4  execute-stage load destination
- branch_taken_ex  in  1  execute resolved a taken branch/BX this cycle
- sel_stall  out  1  hold fetch/decode, inject NOP into execute
- branch_flush  out  1  squash fetch/decode contents (drives branch_in)
- en_pc  out  1  PC update enable
- stall_cnt  out  CNT_W  total stall cycles, saturating
- flush_cnt  out  CNT_W  total flush cycles, saturating
- busy  out  1  FSM not in RUN

Behaviour:
- Reset: a synchronous rst_n low at a clock edge sets state=RUN, the internal down-counter to 0, and stall_cnt and flush_cnt to 0. With state=RUN and inputs idle, sel_stall=0, branch_flush=0, en_pc=1, busy=0. Reset aborts any stall or flush in progress.
- Hazard term (combinational): hz = valid_dec & valid_ex & load_ex & ((use_rn_dec & rn_dec==rd_ex) | (use_rm_dec & rm_dec==rd_ex) | (use_rs_dec & rs_dec==rd_ex)).
- FSM states: RUN, STALL, FLUSH. A 3-bit down-counter cnt is used in STALL and FLUSH.
- RUN:
  - branch_taken_ex=1: branch_flush=1 in the same cycle (combinational). If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else hz=1: sel_stall=1 in the same cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; otherwise stay in RUN.
  - Branch has priority. hz is ignored whenever branch_taken_ex=1 because the decode instruction is wrong-path.
- STALL:
  - sel_stall=1; cnt decrements each cycle; return to RUN when cnt reaches 0 (i.e. at the cycle where cnt=1 is consumed).
  - branch_taken_ex=1 in STALL: abort the stall, assert branch_flush that cycle, and enter FLUSH (or RUN if FLUSH_CYCLES=1).
- FLUSH:
  - branch_flush=1; sel_stall=0; hz is ignored.
  - cnt decrements each cycle; return to RUN when cnt reaches 0.
  - A new branch_taken_ex in FLUSH reloads cnt=FLUSH_CYCLES-1.
- Derived outputs:
  - en_pc = ~sel_stall. The PC must load the branch target during a flush.
  - busy = (state != RUN).
- Counters:
  - stall_cnt increments on every cycle with sel_stall=1; flush_cnt increments on every cycle with branch_flush=1.
  - Both saturate at all-ones and never wrap.
- A single load-use hazard with LOAD_LAT=1 produces exactly one sel_stall cycle. In the following cycle the execute stage holds a NOP, so valid_ex=0 and hz clears naturally without extra state.

Test Plan:
- Load-use on Rm: valid_ex=1, load_ex=1, rd_ex=3; decode valid with use_rm=1, rm=3 -> sel_stall=1 and en_pc=0 for exactly 1 cycle; stall_cnt=1.
- Same hazard with use_rm=0, or with valid_ex=0 -> sel_stall stays 0 and stall_cnt=0. Non-load producer (load_ex=0, rd_ex=3) -> no stall.
- Taken branch, FLUSH_CYCLES=2: branch_taken_ex pulse at cycle t -> branch_flush high at t and t+1, low at t+2; en_pc=1 throughout; flush_cnt=2.
- Simultaneous branch_taken_ex=1 and hz=1 -> branch_flush=1 and sel_stall=0; stall_cnt unchanged.
- LOAD_LAT=3: hazard at t -> sel_stall high t..t+2. Branch arriving at t+1 -> sel_stall low from t+1, branch_flush high t+1..t+2.
- rst_n low for one edge during FLUSH -> next cycle state=RUN with both counters 0. Counter saturation with CNT_W=4: 20 continuous stall cycles -> stall_cnt=15.
